// File: rtl/sram_1rw_share_ctrl.sv
// Arbitrates one 1RW SRAM between a read port and a buffered posted-write port; zero-fills after reset.
// Read data one cycle after grant; reads stall on buffer full, starvation or RAW hit; writes stall when buffer full.
module sram_1rw_share_ctrl #(
  parameter int ADDR_W     = 6,
  parameter int DEPTH      = 64,
  parameter int DATA_W     = 176,
  parameter int MASK_W     = 8,
  parameter int WBUF_DEPTH = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  output logic              init_done,
  input  logic              rd_req_valid,
  output logic              rd_req_ready,
  input  logic [ADDR_W-1:0] rd_req_addr,
  output logic              rd_resp_valid,
  output logic [DATA_W-1:0] rd_resp_data,
  input  logic              wr_req_valid,
  output logic              wr_req_ready,
  input  logic [ADDR_W-1:0] wr_req_addr,
  input  logic [DATA_W-1:0] wr_req_data,
  input  logic [MASK_W-1:0] wr_req_mask,
  output logic [ADDR_W-1:0] RW0_addr,
  output logic              RW0_en,
  output logic              RW0_wmode,
  output logic [DATA_W-1:0] RW0_wdata,
  output logic [MASK_W-1:0] RW0_wmask,
  input  logic [DATA_W-1:0] RW0_rdata
);

  localparam int PTR_W = (WBUF_DEPTH > 1) ? $clog2(WBUF_DEPTH) : 1;
  localparam int CNT_W = $clog2(WBUF_DEPTH + 1);
  localparam int STV_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(WBUF_DEPTH);
  localparam logic [STV_W-1:0]  STV_LIMIT = STV_W'(STARVE_MAX);
  localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(WBUF_DEPTH - 1);

  typedef enum logic {S_INIT, S_RUN} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [MASK_W-1:0] mask;
  } wbuf_entry_t;

  state_t            state_q;
  logic              init_en_q;
  logic [ADDR_W-1:0] init_ptr_q;
  logic              init_done_q;

  wbuf_entry_t           wbuf_mem [WBUF_DEPTH];
  logic [WBUF_DEPTH-1:0] wbuf_vld_q, wbuf_vld_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [STV_W-1:0]      starve_q, starve_d;
  logic                  rd_resp_valid_q, rd_resp_valid_d;

  logic        run, buf_empty, buf_full, raw_hit, force_drain;
  logic        drain, rd_grant, push;
  wbuf_entry_t head;

  // init_en_q lags reset release by one edge so the macro sees no enable while reset is held.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_INIT;
      init_en_q   <= 1'b0;
      init_ptr_q  <= '0;
      init_done_q <= 1'b0;
    end else begin
      case (state_q)
        S_INIT: begin
          if (!init_en_q) begin
            init_en_q <= 1'b1;
          end else if (init_ptr_q == LAST_ADDR) begin
            state_q     <= S_RUN;
            init_en_q   <= 1'b0;
            init_ptr_q  <= '0;
            init_done_q <= 1'b1;
          end else begin
            init_ptr_q <= init_ptr_q + ADDR_W'(1);
          end
        end
        default: state_q <= S_RUN;
      endcase
    end
  end

  always_comb begin
    run       = (state_q == S_RUN);
    buf_empty = (count_q == '0);
    buf_full  = (count_q == CNT_FULL);
    head      = wbuf_mem[rd_ptr_q];

    // Hazard check spans every buffered entry, so a read waits until all older writes to it drain.
    raw_hit = 1'b0;
    for (int i = 0; i < WBUF_DEPTH; i++) begin
      if (wbuf_vld_q[i] && (wbuf_mem[i].addr == rd_req_addr)) raw_hit = 1'b1;
    end
    raw_hit = raw_hit && rd_req_valid;

    force_drain  = !buf_empty && (buf_full || (starve_q == STV_LIMIT) || raw_hit);
    drain        = run && !buf_empty && (force_drain || !rd_req_valid);
    rd_grant     = run && rd_req_valid && !force_drain;
    wr_req_ready = init_done_q && (count_q < CNT_FULL);
    push         = wr_req_valid && wr_req_ready;

    wbuf_vld_d = wbuf_vld_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (drain) begin
      wbuf_vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    if (push) begin
      wbuf_vld_d[wr_ptr_q] = 1'b1;
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push) - CNT_W'(drain);

    if (drain || buf_empty)         starve_d = '0;
    else if (starve_q != STV_LIMIT) starve_d = starve_q + STV_W'(1);
    else                            starve_d = starve_q;

    rd_resp_valid_d = rd_grant;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wbuf_vld_q      <= '0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      starve_q        <= '0;
      rd_resp_valid_q <= 1'b0;
    end else begin
      wbuf_vld_q      <= wbuf_vld_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      starve_q        <= starve_d;
      rd_resp_valid_q <= rd_resp_valid_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) wbuf_mem[wr_ptr_q] <= '{addr: wr_req_addr, data: wr_req_data, mask: wr_req_mask};
  end

  always_comb begin
    RW0_en    = 1'b0;
    RW0_wmode = 1'b0;
    RW0_addr  = '0;
    RW0_wdata = '0;
    RW0_wmask = '0;
    if (state_q == S_INIT) begin
      RW0_en    = init_en_q;
      RW0_wmode = init_en_q;
      RW0_addr  = init_ptr_q;
      RW0_wmask = {MASK_W{init_en_q}};
    end else if (drain) begin
      RW0_en    = 1'b1;
      RW0_wmode = 1'b1;
      RW0_addr  = head.addr;
      RW0_wdata = head.data;
      RW0_wmask = head.mask;
    end else if (rd_grant) begin
      RW0_en   = 1'b1;
      RW0_addr = rd_req_addr;
    end
  end

  assign init_done     = init_done_q;
  assign rd_req_ready  = rd_grant;
  assign rd_resp_valid = rd_resp_valid_q;
  assign rd_resp_data  = RW0_rdata;

endmodule

// File: tb/tb_sram_1rw_share_ctrl.sv
// Directed bench for sram_1rw_share_ctrl with a behavioural masked 1RW SRAM behind the RW0 port.
module tb_sram_1rw_share_ctrl;

  localparam int AW = 6;
  localparam int DEPTH = 64;
  localparam int DW = 176;
  localparam int MW = 8;
  localparam int GW = DW / MW;
  localparam int STARVE = 4;

  localparam logic [DW-1:0] DATA_A = {11{16'hA5C3}};
  localparam logic [DW-1:0] DATA_B = {11{16'h3C5A}};
  localparam logic [DW-1:0] DATA_0 = {22{8'h11}};
  localparam logic [DW-1:0] DATA_1 = {22{8'h7E}};
  localparam logic [DW-1:0] DATA_2 = {11{16'hBEEF}};

  logic          clock = 1'b0;
  logic          reset_n;
  logic          init_done;
  logic          rd_req_valid, rd_req_ready;
  logic [AW-1:0] rd_req_addr;
  logic          rd_resp_valid;
  logic [DW-1:0] rd_resp_data;
  logic          wr_req_valid, wr_req_ready;
  logic [AW-1:0] wr_req_addr;
  logic [DW-1:0] wr_req_data;
  logic [MW-1:0] wr_req_mask;
  logic [AW-1:0] RW0_addr;
  logic          RW0_en, RW0_wmode;
  logic [DW-1:0] RW0_wdata, RW0_rdata;
  logic [MW-1:0] RW0_wmask;

  int total = 0;
  int bad = 0;

  logic [DW-1:0] mem [DEPTH];

  always #5 clock = ~clock;

  sram_1rw_share_ctrl #(
    .ADDR_W(AW), .DEPTH(DEPTH), .DATA_W(DW), .MASK_W(MW), .WBUF_DEPTH(2), .STARVE_MAX(STARVE)
  ) dut (
    .clock(clock), .reset_n(reset_n), .init_done(init_done),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_addr(rd_req_addr),
    .rd_resp_valid(rd_resp_valid), .rd_resp_data(rd_resp_data),
    .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready), .wr_req_addr(wr_req_addr),
    .wr_req_data(wr_req_data), .wr_req_mask(wr_req_mask),
    .RW0_addr(RW0_addr), .RW0_en(RW0_en), .RW0_wmode(RW0_wmode),
    .RW0_wdata(RW0_wdata), .RW0_wmask(RW0_wmask), .RW0_rdata(RW0_rdata)
  );

  function automatic logic [DW-1:0] apply_mask(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                               input logic [MW-1:0] m);
    logic [DW-1:0] r;
    r = old;
    for (int g = 0; g < MW; g++) if (m[g]) r[g*GW +: GW] = d[g*GW +: GW];
    return r;
  endfunction

  // Masked 1RW macro model: write merges per group, read data appears one cycle after enable.
  always @(posedge clock) begin
    if (RW0_en) begin
      if (RW0_wmode) mem[RW0_addr] <= apply_mask(mem[RW0_addr], RW0_wdata, RW0_wmask);
      else           RW0_rdata <= mem[RW0_addr];
    end
  end

  task automatic clr();
    rd_req_valid = 1'b0;
    rd_req_addr  = '0;
    wr_req_valid = 1'b0;
    wr_req_addr  = '0;
    wr_req_data  = '0;
    wr_req_mask  = '0;
  endtask

  task automatic drive_wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [MW-1:0] m);
    wr_req_valid = 1'b1;
    wr_req_addr  = a;
    wr_req_data  = d;
    wr_req_mask  = m;
  endtask

  task automatic check_sweep(input string name);
    for (int c = 0; c < DEPTH; c++) begin
      @(negedge clock);
      total++;
      if ({RW0_en, RW0_wmode, RW0_addr, RW0_wmask, init_done, rd_req_ready, wr_req_ready, rd_resp_valid}
          !== {1'b1, 1'b1, AW'(c), 8'hFF, 4'b0000} || RW0_wdata !== '0) begin
        bad++;
        $display("FAIL %s cycle %0d: en/wm/addr/mask/done/rrdy/wrdy/rvld=%b/%b/%0d/%h/%b/%b/%b/%b wdata=%h want addr %0d",
                 name, c + 1, RW0_en, RW0_wmode, RW0_addr, RW0_wmask, init_done, rd_req_ready,
                 wr_req_ready, rd_resp_valid, RW0_wdata, c);
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    clr();
    repeat (2) @(negedge clock);
    total++;
    if ({init_done, rd_req_ready, wr_req_ready, rd_resp_valid, RW0_en, RW0_wmode} !== 6'b0 ||
        RW0_addr !== '0 || RW0_wdata !== '0 || RW0_wmask !== '0) begin
      bad++;
      $display("FAIL reset_state: done/rrdy/wrdy/rvld/en/wm=%b%b%b%b%b%b addr=%0d mask=%h want all zero",
               init_done, rd_req_ready, wr_req_ready, rd_resp_valid, RW0_en, RW0_wmode, RW0_addr, RW0_wmask);
    end
    rd_req_valid = 1'b1;
    rd_req_addr  = 6'd9;
    drive_wr(6'd9, DATA_A, 8'hFF);
    reset_n = 1'b1;
    check_sweep("init_sweep");
    clr();
    @(negedge clock);
    total++;
    if ({init_done, RW0_en, wr_req_ready} !== 3'b101) begin
      bad++;
      $display("FAIL init_done_rise: done/en/wrdy=%b%b%b want 101", init_done, RW0_en, wr_req_ready);
    end
    total++;
    begin
      int nz = 0;
      for (int i = 0; i < DEPTH; i++) if (mem[i] !== '0) nz++;
      if (nz != 0) begin
        bad++;
        $display("FAIL zero_fill: %0d words nonzero want 0", nz);
      end
    end
  endtask

  task automatic test_read_zero();
    @(negedge clock);
    rd_req_valid = 1'b1;
    rd_req_addr  = 6'd5;
    #1;
    total++;
    if ({rd_req_ready, RW0_en, RW0_wmode, RW0_addr} !== {1'b1, 1'b1, 1'b0, 6'd5}) begin
      bad++;
      $display("FAIL read_grant: rdy/en/wm/addr=%b/%b/%b/%0d want 1/1/0/5", rd_req_ready, RW0_en, RW0_wmode, RW0_addr);
    end
    @(negedge clock);
    clr();
    total++;
    if (rd_resp_valid !== 1'b1 || rd_resp_data !== '0) begin
      bad++;
      $display("FAIL read_resp: vld=%b data=%h want 1 and 0", rd_resp_valid, rd_resp_data);
    end
    @(negedge clock);
    total++;
    if (rd_resp_valid !== 1'b0) begin
      bad++;
      $display("FAIL read_single_resp: vld=%b want 0", rd_resp_valid);
    end
  endtask

  task automatic test_raw();
    @(negedge clock);
    drive_wr(6'd3, DATA_A, 8'hFF);
    #1;
    total++;
    if ({wr_req_ready, RW0_en} !== 2'b10) begin
      bad++;
      $display("FAIL raw_accept: wrdy/en=%b%b want 10", wr_req_ready, RW0_en);
    end
    @(negedge clock);
    clr();
    rd_req_valid = 1'b1;
    rd_req_addr  = 6'd3;
    #1;
    total++;
    if ({rd_req_ready, RW0_en, RW0_wmode, RW0_addr} !== {1'b0, 1'b1, 1'b1, 6'd3} || RW0_wdata !== DATA_A) begin
      bad++;
      $display("FAIL raw_drain_first: rdy/en/wm/addr=%b/%b/%b/%0d wdata=%h want 0/1/1/3 %h",
               rd_req_ready, RW0_en, RW0_wmode, RW0_addr, RW0_wdata, DATA_A);
    end
    @(negedge clock);
    #1;
    total++;
    if ({rd_req_ready, RW0_en, RW0_wmode, RW0_addr} !== {1'b1, 1'b1, 1'b0, 6'd3}) begin
      bad++;
      $display("FAIL raw_read_after: rdy/en/wm/addr=%b/%b/%b/%0d want 1/1/0/3", rd_req_ready, RW0_en, RW0_wmode, RW0_addr);
    end
    @(negedge clock);
    clr();
    total++;
    if (rd_resp_valid !== 1'b1 || rd_resp_data !== DATA_A) begin
      bad++;
      $display("FAIL raw_resp: vld=%b data=%h want 1 %h", rd_resp_valid, rd_resp_data, DATA_A);
    end
  endtask

  task automatic test_starve();
    for (int r = 0; r < 2; r++) begin
      @(negedge clock);
      rd_req_valid = 1'b1;
      rd_req_addr  = 6'd20;
      drive_wr(AW'(10 + r), DATA_B, 8'hFF);
      #1;
      total++;
      if ({rd_req_ready, wr_req_ready} !== 2'b11) begin
        bad++;
        $display("FAIL starve_push r%0d: rrdy/wrdy=%b%b want 11", r, rd_req_ready, wr_req_ready);
      end
      for (int k = 0; k < STARVE; k++) begin
        @(negedge clock);
        wr_req_valid = 1'b0;
        #1;
        total++;
        if ({rd_req_ready, RW0_wmode} !== 2'b10) begin
          bad++;
          $display("FAIL starve_lost r%0d k%0d: rrdy/wm=%b%b want 10", r, k, rd_req_ready, RW0_wmode);
        end
      end
      @(negedge clock);
      #1;
      total++;
      if ({rd_req_ready, RW0_en, RW0_wmode, RW0_addr} !== {1'b0, 1'b1, 1'b1, AW'(10 + r)} || RW0_wdata !== DATA_B) begin
        bad++;
        $display("FAIL starve_drain r%0d: rrdy/en/wm/addr=%b/%b/%b/%0d want 0/1/1/%0d",
                 r, rd_req_ready, RW0_en, RW0_wmode, RW0_addr, 10 + r);
      end
    end
    @(negedge clock);
    clr();
  endtask

  task automatic test_fill_order();
    @(negedge clock);
    rd_req_valid = 1'b1;
    rd_req_addr  = 6'd40;
    drive_wr(6'd30, DATA_0, 8'h0F);
    #1;
    total++;
    if ({rd_req_ready, wr_req_ready} !== 2'b11) begin
      bad++;
      $display("FAIL fill_c1: rrdy/wrdy=%b%b want 11", rd_req_ready, wr_req_ready);
    end
    @(negedge clock);
    drive_wr(6'd31, DATA_1, 8'hF0);
    #1;
    total++;
    if ({rd_req_ready, wr_req_ready} !== 2'b11) begin
      bad++;
      $display("FAIL fill_c2: rrdy/wrdy=%b%b want 11", rd_req_ready, wr_req_ready);
    end
    @(negedge clock);
    drive_wr(6'd32, DATA_2, 8'h3C);
    #1;
    total++;
    if ({rd_req_ready, wr_req_ready, RW0_en, RW0_wmode, RW0_addr, RW0_wmask} !== {4'b0011, 6'd30, 8'h0F} ||
        RW0_wdata !== DATA_0) begin
      bad++;
      $display("FAIL full_drain0: rrdy/wrdy/en/wm=%b%b%b%b addr=%0d mask=%h want 0011 30 0f",
               rd_req_ready, wr_req_ready, RW0_en, RW0_wmode, RW0_addr, RW0_wmask);
    end
    @(negedge clock);
    #1;
    total++;
    if ({rd_req_ready, wr_req_ready, RW0_wmode} !== 3'b110) begin
      bad++;
      $display("FAIL fill_c4: rrdy/wrdy/wm=%b%b%b want 110", rd_req_ready, wr_req_ready, RW0_wmode);
    end
    @(negedge clock);
    clr();
    #1;
    total++;
    if ({wr_req_ready, RW0_en, RW0_wmode, RW0_addr, RW0_wmask} !== {3'b011, 6'd31, 8'hF0} || RW0_wdata !== DATA_1) begin
      bad++;
      $display("FAIL full_drain1: wrdy/en/wm=%b%b%b addr=%0d mask=%h want 011 31 f0",
               wr_req_ready, RW0_en, RW0_wmode, RW0_addr, RW0_wmask);
    end
    @(negedge clock);
    #1;
    total++;
    if ({wr_req_ready, RW0_en, RW0_wmode, RW0_addr, RW0_wmask} !== {3'b111, 6'd32, 8'h3C} || RW0_wdata !== DATA_2) begin
      bad++;
      $display("FAIL drain2: wrdy/en/wm=%b%b%b addr=%0d mask=%h want 111 32 3c",
               wr_req_ready, RW0_en, RW0_wmode, RW0_addr, RW0_wmask);
    end
    @(negedge clock);
    #1;
    total++;
    if (RW0_en !== 1'b0) begin
      bad++;
      $display("FAIL drain_idle: en=%b want 0", RW0_en);
    end
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] addrs [3];
    logic [DW-1:0] exp_d [3];
    addrs[0] = 6'd30; exp_d[0] = apply_mask('0, DATA_0, 8'h0F);
    addrs[1] = 6'd31; exp_d[1] = apply_mask('0, DATA_1, 8'hF0);
    addrs[2] = 6'd32; exp_d[2] = apply_mask('0, DATA_2, 8'h3C);
    for (int i = 0; i <= 3; i++) begin
      @(negedge clock);
      if (i > 0) begin
        total++;
        if (rd_resp_valid !== 1'b1 || rd_resp_data !== exp_d[i-1]) begin
          bad++;
          $display("FAIL b2b_resp%0d: vld=%b data=%h want 1 %h", i - 1, rd_resp_valid, rd_resp_data, exp_d[i-1]);
        end
      end
      if (i < 3) begin
        rd_req_valid = 1'b1;
        rd_req_addr  = addrs[i];
        #1;
        total++;
        if (rd_req_ready !== 1'b1) begin
          bad++;
          $display("FAIL b2b_grant%0d: rdy=%b want 1", i, rd_req_ready);
        end
      end else begin
        clr();
      end
    end
    @(negedge clock);
    total++;
    if (rd_resp_valid !== 1'b0) begin
      bad++;
      $display("FAIL b2b_end: vld=%b want 0", rd_resp_valid);
    end
  endtask

  task automatic test_reset_midop();
    @(negedge clock);
    rd_req_valid = 1'b1;
    rd_req_addr  = 6'd50;
    drive_wr(6'd1, DATA_A, 8'hFF);
    #1;
    total++;
    if ({rd_req_ready, wr_req_ready} !== 2'b11) begin
      bad++;
      $display("FAIL midop_w0: rrdy/wrdy=%b%b want 11", rd_req_ready, wr_req_ready);
    end
    @(negedge clock);
    drive_wr(6'd2, DATA_B, 8'hFF);
    #1;
    total++;
    if ({rd_req_ready, wr_req_ready} !== 2'b11) begin
      bad++;
      $display("FAIL midop_w1: rrdy/wrdy=%b%b want 11", rd_req_ready, wr_req_ready);
    end
    #2;
    reset_n = 1'b0;
    @(negedge clock);
    clr();
    total++;
    if ({rd_resp_valid, RW0_en, init_done, wr_req_ready, rd_req_ready} !== 5'b0) begin
      bad++;
      $display("FAIL midop_in_reset: rvld/en/done/wrdy/rrdy=%b%b%b%b%b want 00000",
               rd_resp_valid, RW0_en, init_done, wr_req_ready, rd_req_ready);
    end
    reset_n = 1'b1;
    check_sweep("sweep_restart");
    @(negedge clock);
    total++;
    if ({init_done, RW0_en, wr_req_ready, rd_resp_valid} !== 4'b1010) begin
      bad++;
      $display("FAIL midop_no_drain: done/en/wrdy/rvld=%b%b%b%b want 1010", init_done, RW0_en, wr_req_ready, rd_resp_valid);
    end
    rd_req_valid = 1'b1;
    rd_req_addr  = 6'd1;
    @(negedge clock);
    clr();
    total++;
    if (rd_resp_valid !== 1'b1 || rd_resp_data !== '0) begin
      bad++;
      $display("FAIL midop_dropped: vld=%b data=%h want 1 and 0", rd_resp_valid, rd_resp_data);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_read_zero();
    test_raw();
    test_starve();
    test_fill_order();
    test_back_to_back();
    test_reset_midop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
